// File: rtl/fv_fifo_pkg.sv
// fv_fifo_pkg: shared defaults and width helpers for the multi-channel FV FIFO.
package fv_fifo_pkg;
  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AF_THRESH = 6;
  localparam int DEF_AE_THRESH = 1;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  // one extra pointer bit tells full from empty when the address bits match
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit params_ok(input int num_ch, input int depth, input int af, input int ae);
    return num_ch >= 1 && depth >= 2 && (depth & (depth - 1)) == 0 &&
           af >= 1 && af <= depth && ae >= 0 && ae < depth;
  endfunction
endpackage

// File: rtl/fv_fifo_channel.sv
// fv_fifo_channel: one FIFO lane with pointers, flags, sticky errors and register-array storage.
module fv_fifo_channel
  import fv_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH,
  localparam int AW       = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rinc,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [AW:0] AF_C = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C = (AW+1)'(AE_THRESH);
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_en, rd_en;
  assign count        = wr_ptr_q - rd_ptr_q;
  assign rempty       = wr_ptr_q == rd_ptr_q;
  assign wfull        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign almost_full  = count >= AF_C;
  assign almost_empty = count <= AE_C;
  // flags are from start-of-cycle state, so a read never frees a slot for a same-cycle write
  assign wr_en = winc && !wfull && !flush;
  assign rd_en = rinc && !rempty && !flush;
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = flush ? '0 : rd_ptr_q + {{AW{1'b0}}, rd_en};
    rdata_d  = rd_en ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    rvalid_d = rd_en;
    ovf_d    = !flush && (ovf_q || (winc && wfull));
    unf_d    = !flush && (unf_q || (rinc && rempty));
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: rtl/fv_multi_sync_fifo.sv
// fv_multi_sync_fifo: bank of NUM_CH independent synchronous FIFOs on one clock,
// with flattened per-channel ports.
module fv_multi_sync_fifo
  import fv_fifo_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH,
  localparam int CW       = ptr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       winc,
  input  logic [NUM_CH*WIDTH-1:0] wdata,
  input  logic [NUM_CH-1:0]       rinc,
  input  logic [NUM_CH-1:0]       flush,
  output logic [NUM_CH*WIDTH-1:0] rdata,
  output logic [NUM_CH-1:0]       rvalid,
  output logic [NUM_CH-1:0]       wfull,
  output logic [NUM_CH-1:0]       rempty,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH-1:0]       almost_empty,
  output logic [NUM_CH*CW-1:0]    count,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       underflow
);
  if (!params_ok(NUM_CH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("fv_multi_sync_fifo: illegal NUM_CH/DEPTH/AF_THRESH/AE_THRESH");
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fv_fifo_channel #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .winc        (winc[c]),
      .wdata       (wdata[c*WIDTH +: WIDTH]),
      .rinc        (rinc[c]),
      .flush       (flush[c]),
      .rdata       (rdata[c*WIDTH +: WIDTH]),
      .rvalid      (rvalid[c]),
      .wfull       (wfull[c]),
      .rempty      (rempty[c]),
      .almost_full (almost_full[c]),
      .almost_empty(almost_empty[c]),
      .count       (count[c*CW +: CW]),
      .overflow    (overflow[c]),
      .underflow   (underflow[c])
    );
  end
endmodule
